// File: rtl/branch_pkg.sv
// Shared opcode constants and the branch condition function for the
// branch resolve unit and its counter table.
package branch_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] BR  = 3'b000;
    localparam logic [OP_W-1:0] BMI = 3'b001;
    localparam logic [OP_W-1:0] BPL = 3'b010;
    localparam logic [OP_W-1:0] BZ  = 3'b011;
    localparam logic [OP_W-1:0] BNZ = 3'b100;

    localparam logic [1:0] BHT_RST = 2'b01;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= BNZ;
    endfunction

    // Operand is pre-reduced to sign and zero flags so this stays width-free.
    function automatic logic br_cond(
        input logic [OP_W-1:0] op,
        input logic            neg,
        input logic            zero
    );
        logic t;
        t = 1'b0;
        unique case (1'b1)
            (op == BR):  t = 1'b1;
            (op == BMI): t = neg;
            (op == BPL): t = !neg && !zero;
            (op == BZ):  t = zero;
            (op == BNZ): t = !zero;
            default:     t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Direct-mapped table of 2-bit saturating taken/not-taken counters,
// one combinational read port and one update port.
module bht_sat_table
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] cnt_q [DEPTH];

    assign rd_taken = cnt_q[rd_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= BHT_RST;
            end
        end else if (wr_en) begin
            if (wr_taken) begin
                if (cnt_q[wr_idx] != 2'b11) begin
                    cnt_q[wr_idx] <= cnt_q[wr_idx] + 2'b01;
                end
            end else if (cnt_q[wr_idx] != 2'b00) begin
                cnt_q[wr_idx] <= cnt_q[wr_idx] - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch condition resolver with registered result, mispredict flagging,
// redirect PC generation and a BHT feeding fetch predictions.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   lk_pc,
    output logic              lk_taken,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   br_op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [PC_W-1:0]   pc,
    input  logic [PC_W-1:0]   target,
    input  logic              pred_taken,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              is_branch,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             legal;
    logic             taken;
    logic             misp;
    logic             accept;
    logic             unused_pc_bits;

    assign lk_idx = lk_pc[IDX_W+1:2];
    assign wr_idx = pc[IDX_W+1:2];

    // Only the index slice of the lookup PC feeds the table.
    assign unused_pc_bits = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0]};

    assign legal  = op_legal(br_op);
    assign taken  = legal && br_cond(br_op, rs_val[DATA_W-1], rs_val == '0);
    assign misp   = taken ^ pred_taken;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    bht_sat_table #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (lk_idx),
        .rd_taken (lk_taken),
        .wr_en    (accept && legal),
        .wr_idx   (wr_idx),
        .wr_taken (taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            is_branch   <= 1'b0;
            mispredict  <= 1'b0;
            illegal_op  <= 1'b0;
            redirect_pc <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            is_branch   <= taken;
            mispredict  <= misp;
            illegal_op  <= !legal;
            redirect_pc <= taken ? target : pc + PC_W'(4);
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_cnt <= '0;
        end else if (accept && misp && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed bench for branch_resolve_unit with a queue
// scoreboard against a behavioural branch/BHT model.
module tb_branch_resolve_unit;

    localparam int DW = 32;
    localparam int PW = 32;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] lk_pc;
    logic          in_valid;
    logic [2:0]    br_op;
    logic [DW-1:0] rs_val;
    logic [PW-1:0] pc;
    logic [PW-1:0] target;
    logic          pred_taken;
    logic          out_ready;

    logic          lk_taken, in_ready, out_valid, is_branch, mispredict, illegal_op;
    logic [PW-1:0] redirect_pc;
    logic [15:0]   mispredict_cnt;

    logic          lk_taken2, in_ready2, out_valid2, is_branch2, mispredict2, illegal_op2;
    logic [PW-1:0] redirect_pc2;
    logic [1:0]    mispredict_cnt2;

    branch_resolve_unit #(.DATA_W(DW), .PC_W(PW), .BHT_DEPTH(D), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_taken(lk_taken),
        .in_valid(in_valid), .in_ready(in_ready), .br_op(br_op), .rs_val(rs_val),
        .pc(pc), .target(target), .pred_taken(pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .is_branch(is_branch),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .illegal_op(illegal_op), .mispredict_cnt(mispredict_cnt)
    );

    branch_resolve_unit #(.DATA_W(DW), .PC_W(PW), .BHT_DEPTH(D), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_taken(lk_taken2),
        .in_valid(in_valid), .in_ready(in_ready2), .br_op(br_op), .rs_val(rs_val),
        .pc(pc), .target(target), .pred_taken(pred_taken),
        .out_valid(out_valid2), .out_ready(out_ready), .is_branch(is_branch2),
        .mispredict(mispredict2), .redirect_pc(redirect_pc2),
        .illegal_op(illegal_op2), .mispredict_cnt(mispredict_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        b;
        bit        m;
        bit [31:0] r;
        bit        il;
        int        c;
    } exp_t;

    exp_t q[$];
    int   bht[D];
    int   mcnt;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(string nm, longint act, longint req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic bit model_taken(bit [2:0] op, bit [31:0] rs);
        case (op)
            3'd0:    return 1'b1;
            3'd1:    return $signed(rs) < 0;
            3'd2:    return $signed(rs) > 0;
            3'd3:    return rs == 0;
            3'd4:    return rs != 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) bht[i] = 1;
        mcnt = 0;
    endtask

    // Reference model: lookup check with pre-update state, then accept.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("lk_taken", lk_taken, bht[lk_pc[5:2]] >= 2);
            if (in_valid && in_ready) begin
                exp_t e;
                int   ix;
                bit   tk;
                tk   = model_taken(br_op, rs_val);
                e.il = br_op > 3'd4;
                e.b  = tk;
                e.m  = tk != pred_taken;
                e.r  = tk ? target : pc + 32'd4;
                if (e.m && mcnt < 65535) mcnt++;
                e.c  = mcnt;
                q.push_back(e);
                ix = pc[5:2];
                if (!e.il) bht[ix] = tk ? ((bht[ix] < 3) ? bht[ix] + 1 : 3)
                                        : ((bht[ix] > 0) ? bht[ix] - 1 : 0);
            end
        end
    end

    // Monitor: every result transfer is popped and compared.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("is_branch", is_branch, e.b);
                chk("mispredict", mispredict, e.m);
                chk("redirect_pc", redirect_pc, e.r);
                chk("illegal_op", illegal_op, e.il);
                chk("mispredict_cnt", mispredict_cnt, e.c);
                chk("mispredict_cnt_w2", mispredict_cnt2, (e.c > 3) ? 3 : e.c);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic issue(bit [2:0] op, bit [31:0] rs, bit [31:0] p,
                         bit [31:0] t, bit pr, bit rr);
        bit acc;
        acc        = 1'b0;
        in_valid   = 1'b1;
        br_op      = op;
        rs_val     = rs;
        pc         = p;
        target     = t;
        pred_taken = pr;
        for (int k = 0; k < 64 && !acc; k++) begin
            if (rr) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("issue_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", out_valid, 0);
    endtask

    bit [31:0] vals[4] = '{32'h8000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0001};

    initial begin
        model_reset();
        rst_n      = 1'b0;
        lk_pc      = '0;
        in_valid   = 1'b0;
        br_op      = '0;
        rs_val     = '0;
        pc         = '0;
        target     = '0;
        pred_taken = 1'b0;
        out_ready  = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_is_branch", is_branch, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_cnt", mispredict_cnt, 0);
        chk("rst_lk", lk_taken, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Illegal opcode leaves entry 0 untouched.
        lk_pc = 32'h100;
        issue(3'b110, 32'h0, 32'h100, 32'h2000, 1'b1, 1'b0);
        @(negedge clk);
        chk("ill_valid", out_valid, 1);
        chk("ill_is_branch", is_branch, 0);
        chk("ill_flag", illegal_op, 1);
        chk("ill_misp", mispredict, 1);
        chk("ill_redirect", redirect_pc, 32'h104);
        chk("ill_lk", lk_taken, 0);
        @(posedge clk);
        #1;

        // Saturate up with BR, then back down with not-taken BZ.
        lk_pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            issue(3'd0, 32'h0, 32'h40, 32'h80, 1'($urandom_range(0, 1)), 1'b0);
            if (i == 0) chk("sat_first_up", lk_taken, 1);
        end
        chk("sat_top", lk_taken, 1);
        for (int i = 0; i < 4; i++) begin
            issue(3'd3, 32'h1, 32'h40, 32'h80, 1'($urandom_range(0, 1)), 1'b0);
        end
        chk("sat_bottom", lk_taken, 0);

        // Condition decode, back to back.
        for (int op = 0; op < 5; op++) begin
            for (int v = 0; v < 4; v++) begin
                issue(3'(op), vals[v], $urandom & 32'hffff_fffc, $urandom,
                      1'($urandom_range(0, 1)), 1'b0);
            end
        end
        drain();

        // Backpressure, then pop and accept in the same cycle.
        out_ready = 1'b0;
        issue(3'd4, 32'h5, 32'h200, 32'h300, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_redirect", redirect_pc, 32'h300);
            chk("bp_is_branch", is_branch, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(3'd3, 32'h0, 32'h400, 32'h500, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_redirect", redirect_pc, 32'h500);
        @(posedge clk);
        #1;
        drain();

        // Asynchronous reset while a result is stalled.
        out_ready = 1'b0;
        issue(3'd0, 32'h0, 32'h44, 32'h48, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_cnt", mispredict_cnt, 0);
        chk("arst_cnt_w2", mispredict_cnt2, 0);
        chk("arst_in_ready", in_ready, 1);
        q.delete();
        model_reset();
        for (int i = 0; i < D; i++) begin
            lk_pc = 32'(i << 2);
            #1 chk("arst_lk", lk_taken, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mispredict statistics with saturation on the narrow counter.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue(3'd0, 32'h0, 32'(i << 2), 32'h1000, !(i == 2 || i == 5 || i == 8), 1'b0);
        end
        drain();
        chk("stat_cnt", mispredict_cnt, 3);
        chk("stat_cnt_w2", mispredict_cnt2, 3);
        issue(3'd0, 32'h0, 32'h0, 32'h1000, 1'b0, 1'b0);
        issue(3'd0, 32'h0, 32'h4, 32'h1000, 1'b0, 1'b0);
        drain();
        chk("stat_cnt5", mispredict_cnt, 5);
        chk("stat_sat_w2", mispredict_cnt2, 3);

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 300; i++) begin
            bit [31:0] rs;
            case ($urandom_range(0, 3))
                0:       rs = 32'h0;
                1:       rs = 32'h8000_0000 | $urandom;
                2:       rs = 32'($urandom_range(1, 7));
                default: rs = $urandom;
            endcase
            lk_pc = $urandom;
            issue(3'($urandom_range(0, 7)), rs, $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'b1);
        end
        drain();
        chk("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
